// File: rtl/hack_pkg.sv
// Shared word-size definitions for the Hack-style datapath.
package hack_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/register_bit.sv
// One stored bit: a flop with async active-low clear and a load/hold feedback mux.
module register_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic load,
  output logic out
);

  // Capture in when load is high, otherwise recirculate the stored bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= load ? in : out;
  end

endmodule

// File: rtl/student_register.sv
// WIDTH-bit load-enabled word register built from one register_bit per bit.
// out comes straight from the flops; in/load never reach out combinationally.
module student_register
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  // A zero-width register has no meaning; stop elaboration early.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("student_register: WIDTH must be >= 1");
    end
  endgenerate

  // All bits share clk, rst_n and load; bit i of in feeds bit i of out.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      register_bit u_bit (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in[i]),
        .load (load),
        .out  (out[i])
      );
    end
  endgenerate

  // An unknown load would make the stored word unpredictable.
  a_load_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(load))
    else $error("student_register: load is X/Z while out of reset");

endmodule

// File: tb/tb_student_register.sv
// Scoreboard bench for student_register: stimulus pushes expected words,
// a monitor pops and compares them on every falling clock edge.
module tb_student_register;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic         load;
  logic [W-1:0] out;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_done = 0;

  student_register #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .load (load),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected word per falling edge, compared against out.
  initial begin
    while (!mon_done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
          errors++;
          $display("FAIL out_word: got %h expected %h at %0t", out, e, $time);
        end
      end
    end
  end

  // One clock edge with the given controls; in is scrambled just after the
  // edge so any combinational path from in to out would be caught.
  task automatic step(input logic ld, input logic [W-1:0] din, input logic [W-1:0] exp);
    @(negedge clk);
    #1;
    load = ld;
    in   = din;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in = ~din;
  endtask

  logic [W-1:0] prev;
  logic [W-1:0] pat;

  initial begin
    rst_n = 1'b0;
    load  = 1'b1;
    in    = 16'd12345;

    // Reset held with load=1 and clock running: out must stay 0.
    repeat (3) begin
      @(posedge clk);
      exp_q.push_back(16'h0000);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // First load after release.
    step(1'b1, 16'd12345, 16'h3039);

    // Store -32123 (16'h8285), then hold against in=11111.
    step(1'b1, 16'h8285, 16'h8285);
    repeat (3) step(1'b0, 16'd11111, 16'h8285);

    // Reload same value twice, then a new value lands after one edge.
    repeat (2) step(1'b1, 16'h8285, 16'h8285);
    step(1'b1, 16'd12345, 16'h3039);

    // Walking ones: hold edge then load edge.
    prev = 16'h3039;
    for (int k = 0; k < 16; k++) begin
      pat = 16'h0001 << k;
      step(1'b0, pat, prev);
      step(1'b1, pat, pat);
      prev = pat;
    end

    // Walking zeros, ending with 32767.
    for (int k = 0; k < 15; k++) begin
      pat = ~(16'h0001 << k);
      step(1'b0, pat, prev);
      step(1'b1, pat, pat);
      prev = pat;
    end
    step(1'b0, 16'h7FFF, prev);
    step(1'b1, 16'h7FFF, 16'h7FFF);

    // Async reset pulse between edges: out clears before the next edge.
    @(posedge clk);
    #1;
    load = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.push_back(16'h0000);
    #1;
    rst_n = 1'b1;
    // Held value after the pulse stays cleared.
    step(1'b0, 16'h1234, 16'h0000);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
    end
    @(posedge clk);
    mon_done = 1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
